// File: rtl/seg_scan_ctrl_if.sv
// Host-side bundle for the seven-segment scan controller: register-file writes,
// scan controls, and the num/sel/dp/blank triple handed to the segment decoder.
interface seg_scan_ctrl_if;
    logic       en;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic [7:0] digit_mask;
    logic       lzs;
    logic [3:0] num;
    logic [2:0] sel;
    logic       dp;
    logic       blank;
    logic       frame_done;

    modport master (
        output en, wr_en, wr_addr, wr_data, wr_dp, digit_mask, lzs,
        input  num, sel, dp, blank, frame_done
    );

    modport slave (
        input  en, wr_en, wr_addr, wr_data, wr_dp, digit_mask, lzs,
        output num, sel, dp, blank, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit scan controller with gap blanking, digit masking,
// leading-zero suppression and a frame-done pulse; all outputs registered.
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GAP_CYCLES  = 1000
) (
    input  logic           clk,
    input  logic           rst_n,
    seg_scan_ctrl_if.slave bus
);
    localparam int unsigned CW     = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CntMax = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GapEnd = CW'(GAP_CYCLES);
    localparam bit HasGap = (GAP_CYCLES != 0);

    typedef enum logic [1:0] {StOff, StGap, StShow} state_e;

    state_e        state_q, state_d, slot_start;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    ptr_q, ptr_d;

    logic [3:0] val_q [8];
    logic [7:0] dpf_q;
    logic [7:0] nz;
    logic [7:0] upper_nz;
    logic       suppressed;

    logic [3:0] num_q, num_d;
    logic [2:0] sel_q, sel_d;
    logic       dp_q, dp_d;
    logic       blank_q, blank_d;
    logic       frame_done_q, frame_done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StOff;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        slot_start = HasGap ? StGap : StShow;
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        if (!bus.en) begin
            state_d = StOff;
            cnt_d   = '0;
            ptr_d   = '0;
        end else if (state_q == StOff) begin
            state_d = slot_start;
            cnt_d   = '0;
            ptr_d   = '0;
        end else if (cnt_q == CntMax) begin
            state_d = slot_start;
            cnt_d   = '0;
            ptr_d   = ptr_q + 3'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
            if (state_q == StGap && cnt_d == GapEnd) begin
                state_d = StShow;
            end
        end
    end

    // upper_nz[k] is set when any of entries k..7 holds a non-zero value
    always_comb begin
        nz = '0;
        for (int j = 0; j < 8; j++) begin
            nz[j] = (val_q[j] != 4'd0);
        end
    end

    always_comb begin
        upper_nz = '0;
        for (int k = 0; k < 8; k++) begin
            upper_nz[k] = |(nz >> k);
        end
    end

    // Outputs are computed from the next pointer so sel/num/dp move together.
    always_comb begin
        sel_d        = ptr_d;
        num_d        = val_q[ptr_d];
        dp_d         = dpf_q[ptr_d];
        suppressed   = bus.lzs && (ptr_d != 3'd0) && !upper_nz[ptr_d];
        blank_d      = (state_d != StShow) || !bus.digit_mask[ptr_d] || suppressed;
        frame_done_d = bus.en && (state_q != StOff) && (cnt_q == CntMax) && (ptr_q == 3'd7);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q        <= '0;
            sel_q        <= '0;
            dp_q         <= 1'b0;
            blank_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            num_q        <= num_d;
            sel_q        <= sel_d;
            dp_q         <= dp_d;
            blank_q      <= blank_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                val_q[i] <= '0;
            end
            dpf_q <= '0;
        end else if (bus.wr_en) begin
            val_q[bus.wr_addr] <= bus.wr_data;
            dpf_q[bus.wr_addr] <= bus.wr_dp;
        end
    end

    assign bus.num        = num_q;
    assign bus.sel        = sel_q;
    assign bus.dp         = dp_q;
    assign bus.blank      = blank_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (gap 2 and gap 0) share stimulus and are
// compared every cycle against a time-since-enable reference model.
module tb_seg_scan_ctrl;
    localparam int RD  = 8;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic rst_n;

    seg_scan_ctrl_if ia ();
    seg_scan_ctrl_if iz ();

    assign iz.en         = ia.en;
    assign iz.wr_en      = ia.wr_en;
    assign iz.wr_addr    = ia.wr_addr;
    assign iz.wr_data    = ia.wr_data;
    assign iz.wr_dp      = ia.wr_dp;
    assign iz.digit_mask = ia.digit_mask;
    assign iz.lzs        = ia.lzs;

    seg_scan_ctrl #(.REFRESH_DIV(RD), .GAP_CYCLES(GAP)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia)
    );

    seg_scan_ctrl #(.REFRESH_DIV(RD), .GAP_CYCLES(0)) dut_z (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (iz)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // t counts cycles since the scan was enabled; -1 means OFF
    int         t = -1;
    logic [3:0] m_val [8];
    bit         m_dp  [8];
    int         cur_sel;
    int         cur_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0d, time %0t)", tag, obs, exp, t, $time);
        end
    endtask

    function automatic bit m_sup(input int k, input bit lz);
        if (!lz || k == 0) return 1'b0;
        for (int j = k; j < 8; j++) begin
            if (m_val[j] != 4'd0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic tick();
        int   sel, cnt;
        bit   off, fd, ba, bz, edp;
        logic [3:0] enum_v;
        @(posedge clk);
        if (!ia.en) t = -1;
        else        t = t + 1;
        off    = (t < 0);
        sel    = off ? 0 : (t / RD) % 8;
        cnt    = off ? 0 : t % RD;
        fd     = !off && t > 0 && (t % (8 * RD)) == 0;
        bz     = off || !ia.digit_mask[sel] || m_sup(sel, ia.lzs);
        ba     = bz || (cnt < GAP);
        enum_v = m_val[sel];
        edp    = m_dp[sel];
        if (ia.wr_en) begin
            m_val[ia.wr_addr] = ia.wr_data;
            m_dp[ia.wr_addr]  = ia.wr_dp;
        end
        cur_sel = sel;
        cur_cnt = cnt;
        #1;
        check_eq("a_sel",   32'(ia.sel),        32'(sel));
        check_eq("a_num",   32'(ia.num),        32'(enum_v));
        check_eq("a_dp",    32'(ia.dp),         32'(edp));
        check_eq("a_blank", 32'(ia.blank),      32'(ba));
        check_eq("a_fdone", 32'(ia.frame_done), 32'(fd));
        check_eq("z_sel",   32'(iz.sel),        32'(sel));
        check_eq("z_num",   32'(iz.num),        32'(enum_v));
        check_eq("z_dp",    32'(iz.dp),         32'(edp));
        check_eq("z_blank", 32'(iz.blank),      32'(bz));
        check_eq("z_fdone", 32'(iz.frame_done), 32'(fd));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_num"},   32'(ia.num),        32'd0);
        check_eq({tag, "_sel"},   32'(ia.sel),        32'd0);
        check_eq({tag, "_dp"},    32'(ia.dp),         32'd0);
        check_eq({tag, "_blank"}, 32'(ia.blank),      32'd1);
        check_eq({tag, "_fdone"}, 32'(ia.frame_done), 32'd0);
        check_eq({tag, "_zblank"}, 32'(iz.blank),     32'd1);
        check_eq({tag, "_znum"},  32'(iz.num),        32'd0);
    endtask

    // Called just after a tick; asserts reset between edges.
    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_async");
        for (int i = 0; i < 8; i++) begin
            m_val[i] = '0;
            m_dp[i]  = 1'b0;
        end
        t = -1;
        ia.en    = 1'b0;
        ia.wr_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 check_reset_outputs("rst_hold");
        rst_n = 1'b1;
    endtask

    task automatic write_digit(input int addr, input int data, input bit dpv);
        ia.wr_en   = 1'b1;
        ia.wr_addr = 3'(addr);
        ia.wr_data = 4'(data);
        ia.wr_dp   = dpv;
        tick();
        ia.wr_en = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        ia.en         = 1'b0;
        ia.wr_en      = 1'b0;
        ia.wr_addr    = '0;
        ia.wr_data    = '0;
        ia.wr_dp      = 1'b0;
        ia.digit_mask = 8'hFF;
        ia.lzs        = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_val[i] = '0;
            m_dp[i]  = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("por");
        rst_n = 1'b1;

        // Reset/OFF: run with content, reset mid-run, then stay off
        for (int i = 0; i < 8; i++) write_digit(i, 15 - i, i[0]);
        ia.en = 1'b1;
        repeat (30) tick();
        mid_reset();
        repeat (20) tick();

        // Basic scan
        for (int i = 0; i < 8; i++) write_digit(i, i + 1, i == 3);
        ia.en = 1'b1;
        repeat (140) tick();

        // Mask and leading-zero suppression
        write_digit(0, 5, 1'b0);
        write_digit(1, 0, 1'b0);
        write_digit(2, 3, 1'b0);
        for (int i = 3; i < 8; i++) write_digit(i, 0, 1'b0);
        ia.lzs = 1'b1;
        repeat (70) tick();
        ia.digit_mask = 8'hFE;
        repeat (70) tick();
        ia.digit_mask = 8'hFF;
        ia.lzs        = 1'b0;

        // Live write to the selected digit during SHOW
        for (int i = 0; i < 200 && !(cur_sel == 4 && cur_cnt >= GAP && cur_cnt < RD - 2); i++)
            tick();
        check_eq("reach_sel4", 32'(ia.sel), 32'd4);
        write_digit(4, 9, 1'b0);
        tick();
        check_eq("live_num", 32'(ia.num), 32'd9);
        repeat (10) tick();

        // Abort mid-slot
        for (int i = 0; i < 200 && !(cur_sel == 5 && cur_cnt == 3); i++) tick();
        check_eq("reach_sel5", 32'(ia.sel), 32'd5);
        ia.en = 1'b0;
        repeat (5) tick();
        ia.en = 1'b1;
        repeat (20) tick();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            ia.wr_en   = ($urandom_range(0, 3) == 0);
            ia.wr_addr = 3'($urandom_range(0, 7));
            ia.wr_data = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            ia.wr_dp   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0)
                ia.digit_mask = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            if ($urandom_range(0, 49) == 0) ia.lzs = ~ia.lzs;
            if (ia.en) begin
                if ($urandom_range(0, 149) == 0) ia.en = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                ia.en = 1'b1;
            end
            if (i == 1000) mid_reset();
            else           tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
